temp_poll_ctrl: RTL

TEMP_POLL_CTRL -- requirements
Module: temp_poll_ctrl

---
 rtl/temp_poll_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/temp_poll_ctrl.sv
// rtl/temp_poll_ctrl.sv - periodic I2C temperature poller with retry, 4-sample average and overrun count
//
// Purpose: every INTERVAL cycles (while enable=1) issue a 2-byte read of register 0
// at I2C_ADDR, retry failed reads up to MAX_RETRY times, publish the last good raw
// sample and a 4-sample moving average, and count poll ticks lost while busy.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   enable                     polling enable (level)
//   cmd_valid/cmd_ready        read command handshake to the I2C engine
//   cmd_addr/cmd_reg/cmd_len   constant command fields
//   rsp_valid/rsp_nack/rsp_data  end-of-transaction pulse, failure flag, raw sample
//   temp/temp_avg/temp_valid   last good sample, moving average, update pulse
//   busy                       high whenever not IDLE
//   err/err_clr                sticky retries-exhausted flag and its clear
//   overrun                    saturating count of dropped ticks
module temp_poll_ctrl #(
    parameter int         INTERVAL  = 10000,
    parameter logic [6:0] I2C_ADDR  = 7'h4B,
    parameter int         TIMEOUT   = 4096,
    parameter int         MAX_RETRY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [6:0]         cmd_addr,
    output logic [7:0]         cmd_reg,
    output logic [1:0]         cmd_len,
    input  logic               rsp_valid,
    input  logic               rsp_nack,
    input  logic [15:0]        rsp_data,
    output logic signed [15:0] temp,
    output logic signed [15:0] temp_avg,
    output logic               temp_valid,
    output logic               busy,
    output logic               err,
    input  logic               err_clr,
    output logic [7:0]         overrun
);

    localparam int CNT_W = $clog2(INTERVAL);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        UPDATE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    wait_q, wait_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               temp_valid_q, temp_valid_d;
    logic               filled_q, filled_d;
    logic [7:0]         overrun_q, overrun_d;
    logic signed [15:0] temp_q, temp_d;
    logic signed [15:0] avg_q, avg_d;
    logic [3:0][15:0]   win_q, win_d;
    logic signed [17:0] sum;
    logic               tick;
    logic               fail;
    logic               err_set;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        retry_d      = retry_q;
        temp_d       = temp_q;
        win_d        = win_q;
        filled_d     = filled_q;
        overrun_d    = overrun_q;
        temp_valid_d = 1'b0;
        fail         = 1'b0;
        err_set      = 1'b0;

        tick = enable && (cnt_q == CNT_LAST);

        if (!enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A tick arriving while a transaction is in flight is lost, only counted.
        if (tick && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_valid_q && cmd_ready) begin
                    state_d = WAIT_RSP;
                    wait_d  = '0;
                end
            end
            WAIT_RSP: begin
                wait_d = wait_q + TO_W'(1);
                if (rsp_valid && !rsp_nack) begin
                    // Results are registered on the way into UPDATE so that
                    // temp, temp_avg and temp_valid are all visible during UPDATE.
                    state_d      = UPDATE;
                    temp_d       = rsp_data;
                    temp_valid_d = 1'b1;
                    filled_d     = 1'b1;
                    if (filled_q) begin
                        win_d = {win_q[2:0], rsp_data};
                    end else begin
                        win_d = {4{rsp_data}};
                    end
                end else if ((rsp_valid && rsp_nack) || (wait_q == TO_LAST)) begin
                    fail = 1'b1;
                end
                if (fail) begin
                    if (retry_q < RTY_MAX) begin
                        state_d = ISSUE;
                        retry_d = retry_q + RTY_W'(1);
                    end else begin
                        state_d = IDLE;
                        err_set = 1'b1;
                    end
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            retry_d = '0;
        end

        sum = {{2{win_d[0][15]}}, win_d[0]} + {{2{win_d[1][15]}}, win_d[1]}
            + {{2{win_d[2][15]}}, win_d[2]} + {{2{win_d[3][15]}}, win_d[3]};
        avg_d = (state_q == WAIT_RSP && temp_valid_d) ? 16'(sum >>> 2) : avg_q;

        // Set beats clear when both happen in the same cycle.
        err_d       = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
        cmd_valid_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wait_q       <= '0;
            retry_q      <= '0;
            cmd_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            temp_valid_q <= 1'b0;
            filled_q     <= 1'b0;
            overrun_q    <= 8'd0;
            temp_q       <= '0;
            avg_q        <= '0;
            win_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            retry_q      <= retry_d;
            cmd_valid_q  <= cmd_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            temp_valid_q <= temp_valid_d;
            filled_q     <= filled_d;
            overrun_q    <= overrun_d;
            temp_q       <= temp_d;
            avg_q        <= avg_d;
            win_q        <= win_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_addr   = I2C_ADDR;
    assign cmd_reg    = 8'h00;
    assign cmd_len    = 2'd2;
    assign temp       = temp_q;
    assign temp_avg   = avg_q;
    assign temp_valid = temp_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign overrun    = overrun_q;

endmodule
